// File: rtl/armleocpu_axi_refill_unit_pkg.sv
// Shared AXI encodings and FSM state type for the cache refill/write-through master.
package armleocpu_axi_refill_unit_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B
    } state_t;

endpackage

// File: rtl/armleocpu_axi_refill_unit_if.sv
// AXI4 bus (AW/W/B/AR/R) between the refill master and its slave.
interface armleocpu_axi_refill_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [ID_WIDTH-1:0]   awid;

    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic [ID_WIDTH-1:0]   bid;

    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [ID_WIDTH-1:0]   arid;

    logic                  rvalid;
    logic                  rready;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [31:0]           rdata;
    logic [ID_WIDTH-1:0]   rid;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst, awid,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        input  bvalid, bresp, bid,
        output bready,
        output arvalid, araddr, arlen, arsize, arburst, arid,
        input  arready,
        input  rvalid, rresp, rlast, rdata, rid,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst, awid,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        output bvalid, bresp, bid,
        input  bready,
        input  arvalid, araddr, arlen, arsize, arburst, arid,
        output arready,
        output rvalid, rresp, rlast, rdata, rid,
        input  rready
    );

endinterface

// File: rtl/armleocpu_axi_refill_unit.sv
// Cache-side request to AXI4: critical-word-first WRAP line refill or single-beat write-through.
module armleocpu_axi_refill_unit
    import armleocpu_axi_refill_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int AXI_ID     = 0,
    parameter int LINE_WORDS = 16,
    localparam int IDX_W     = $clog2(LINE_WORDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [3:0]            req_wstrb,

    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [IDX_W-1:0]      resp_index,
    output logic                  resp_last,
    output logic                  resp_error,

    armleocpu_axi_refill_unit_if.master axi
);

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:2] addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic [3:0]            wstrb_reg, wstrb_next;
    logic [IDX_W-1:0]      start_reg, start_next;
    logic [IDX_W-1:0]      cnt_reg, cnt_next;
    logic                  arvalid_reg, arvalid_next;
    logic                  awvalid_reg, awvalid_next;
    logic                  wvalid_reg, wvalid_next;

    logic beat_last;
    logic aw_done;
    logic w_done;
    logic unused_bits;

    assign beat_last   = (cnt_reg == IDX_W'(LINE_WORDS - 1));
    // A channel counts as done once its valid has dropped or its handshake is happening now.
    assign aw_done     = !awvalid_reg || axi.awready;
    assign w_done      = !wvalid_reg || axi.wready;
    assign unused_bits = ^{req_addr[1:0], axi.rresp[0], axi.bresp[0], axi.rid, axi.bid};

    assign axi.arvalid = arvalid_reg;
    assign axi.araddr  = {addr_reg, 2'b00};
    assign axi.arlen   = 8'(LINE_WORDS - 1);
    assign axi.arsize  = AXI_SIZE_WORD;
    assign axi.arburst = AXI_BURST_WRAP;
    assign axi.arid    = ID_WIDTH'(AXI_ID);

    assign axi.awvalid = awvalid_reg;
    assign axi.awaddr  = {addr_reg, 2'b00};
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = AXI_SIZE_WORD;
    assign axi.awburst = AXI_BURST_INCR;
    assign axi.awid    = ID_WIDTH'(AXI_ID);

    assign axi.wvalid  = wvalid_reg;
    assign axi.wdata   = wdata_reg;
    assign axi.wstrb   = wstrb_reg;
    assign axi.wlast   = 1'b1;

    assign resp_data   = axi.rdata;

    always_comb begin
        state_next   = state_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        wstrb_next   = wstrb_reg;
        start_next   = start_reg;
        cnt_next     = cnt_reg;
        arvalid_next = arvalid_reg;
        awvalid_next = awvalid_reg;
        wvalid_next  = wvalid_reg;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        resp_index   = start_reg;
        resp_last    = 1'b0;
        resp_error   = 1'b0;
        axi.rready   = 1'b0;
        axi.bready   = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                req_ready = rst_n;
                if (req_valid) begin
                    addr_next  = req_addr[ADDR_WIDTH-1:2];
                    wdata_next = req_wdata;
                    wstrb_next = req_wstrb;
                    start_next = req_addr[IDX_W+1:2];
                    cnt_next   = '0;
                    if (req_write) begin
                        state_next   = ST_AWW;
                        awvalid_next = 1'b1;
                        wvalid_next  = 1'b1;
                    end else begin
                        state_next   = ST_AR;
                        arvalid_next = 1'b1;
                    end
                end
            end
            ST_AR: begin
                if (axi.arready) begin
                    arvalid_next = 1'b0;
                    cnt_next     = '0;
                    state_next   = ST_R;
                end
            end
            ST_R: begin
                axi.rready = resp_ready;
                resp_valid = axi.rvalid;
                resp_index = start_reg + cnt_reg;
                resp_last  = beat_last;
                // The local beat count is authoritative; a misplaced rlast is reported, not obeyed.
                resp_error = axi.rresp[1] | (axi.rlast != beat_last);
                if (axi.rvalid && resp_ready) begin
                    cnt_next = cnt_reg + 1'b1;
                    if (beat_last) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_AWW: begin
                if (awvalid_reg && axi.awready) begin
                    awvalid_next = 1'b0;
                end
                if (wvalid_reg && axi.wready) begin
                    wvalid_next = 1'b0;
                end
                if (aw_done && w_done) begin
                    state_next = ST_B;
                end
            end
            ST_B: begin
                axi.bready = resp_ready;
                resp_valid = axi.bvalid;
                resp_last  = 1'b1;
                resp_error = axi.bresp[1];
                if (axi.bvalid && resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
            start_reg   <= '0;
            cnt_reg     <= '0;
            arvalid_reg <= 1'b0;
            awvalid_reg <= 1'b0;
            wvalid_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            wstrb_reg   <= wstrb_next;
            start_reg   <= start_next;
            cnt_reg     <= cnt_next;
            arvalid_reg <= arvalid_next;
            awvalid_reg <= awvalid_next;
            wvalid_reg  <= wvalid_next;
        end
    end

endmodule

// File: tb/tb_armleocpu_axi_refill_unit.sv
// Directed bench: BRAM-like AXI slave model with tunable AW/W latency, response collector, per-scenario tasks.
module tb_armleocpu_axi_refill_unit;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_index;
    logic        resp_last;
    logic        resp_error;

    int vectors = 0;
    int miscompares = 0;

    armleocpu_axi_refill_unit_if #(.ADDR_WIDTH(32), .ID_WIDTH(4)) axi_bus ();

    armleocpu_axi_refill_unit #(
        .ADDR_WIDTH(32), .ID_WIDTH(4), .AXI_ID(0), .LINE_WORDS(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_index(resp_index), .resp_last(resp_last), .resp_error(resp_error),
        .axi(axi_bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- slave model ----------------
    logic [31:0] mem [0:DEPTH-1];
    int          aw_lat = 0, w_lat = 0, aw_wait, w_wait;
    logic        aw_got, w_got;
    logic [31:0] aw_addr_s, w_data_s;
    logic [7:0]  aw_len_s;
    logic [1:0]  aw_burst_s;
    logic [3:0]  w_strb_s;
    logic        w_last_s;
    logic [31:0] ar_addr_s;
    logic [7:0]  ar_len_s;
    logic [1:0]  ar_burst_s;
    logic [2:0]  ar_size_s;
    logic        r_active;
    logic [31:0] r_addr;
    logic [7:0]  r_len, r_beat;
    int          b_count = 0;
    int          cyc = 0, aw_hs_cyc = 0, w_hs_cyc = 0;

    function automatic logic [31:0] wrap_next(input logic [31:0] a, input logic [7:0] len);
        logic [31:0] mask;
        mask = ((32'(len) + 32'd1) << 2) - 32'd1;
        return (a & ~mask) | ((a + 32'd4) & mask);
    endfunction

    assign axi_bus.awready = axi_bus.awvalid && !aw_got && (aw_wait >= aw_lat);
    assign axi_bus.wready  = axi_bus.wvalid && !w_got && (w_wait >= w_lat);
    assign axi_bus.arready = axi_bus.arvalid && !r_active;
    assign axi_bus.rvalid  = r_active;
    assign axi_bus.rdata   = (r_addr < 32'(DEPTH * 4)) ? mem[r_addr[11:2]] : 32'h0;
    assign axi_bus.rresp   = (r_addr < 32'(DEPTH * 4)) ? 2'b00 : 2'b10;
    assign axi_bus.rlast   = r_active && (r_beat == r_len);
    assign axi_bus.rid     = 4'd0;
    assign axi_bus.bid     = 4'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_got <= 1'b0; w_got <= 1'b0; aw_wait <= 0; w_wait <= 0;
            axi_bus.bvalid <= 1'b0; axi_bus.bresp <= 2'b00;
            r_active <= 1'b0; r_addr <= 32'h0; r_len <= 8'h0; r_beat <= 8'h0;
        end else begin
            cyc <= cyc + 1;
            if (axi_bus.awvalid && axi_bus.awready) begin
                aw_got <= 1'b1; aw_wait <= 0; aw_hs_cyc <= cyc;
                aw_addr_s <= axi_bus.awaddr; aw_len_s <= axi_bus.awlen; aw_burst_s <= axi_bus.awburst;
            end else if (axi_bus.awvalid && !aw_got) begin
                aw_wait <= aw_wait + 1;
            end
            if (axi_bus.wvalid && axi_bus.wready) begin
                w_got <= 1'b1; w_wait <= 0; w_hs_cyc <= cyc;
                w_data_s <= axi_bus.wdata; w_strb_s <= axi_bus.wstrb; w_last_s <= axi_bus.wlast;
            end else if (axi_bus.wvalid && !w_got) begin
                w_wait <= w_wait + 1;
            end
            if (aw_got && w_got && !axi_bus.bvalid) begin
                aw_got <= 1'b0; w_got <= 1'b0;
                axi_bus.bvalid <= 1'b1;
                if (aw_addr_s < 32'(DEPTH * 4)) begin
                    for (int b = 0; b < 4; b++)
                        if (w_strb_s[b]) mem[aw_addr_s[11:2]][b*8 +: 8] <= w_data_s[b*8 +: 8];
                    axi_bus.bresp <= 2'b00;
                end else begin
                    axi_bus.bresp <= 2'b10;
                end
            end
            if (axi_bus.bvalid && axi_bus.bready) begin
                axi_bus.bvalid <= 1'b0;
                b_count <= b_count + 1;
            end
            if (axi_bus.arvalid && axi_bus.arready) begin
                r_active <= 1'b1; r_addr <= axi_bus.araddr; r_len <= axi_bus.arlen; r_beat <= 8'h0;
                ar_addr_s <= axi_bus.araddr; ar_len_s <= axi_bus.arlen;
                ar_burst_s <= axi_bus.arburst; ar_size_s <= axi_bus.arsize;
            end
            if (r_active && axi_bus.rready) begin
                r_beat <= r_beat + 8'd1;
                r_addr <= wrap_next(r_addr, r_len);
                if (r_beat == r_len) r_active <= 1'b0;
            end
        end
    end

    // ---------------- protocol monitor and response collector ----------------
    logic prev_aw_hs, prev_w_hs, prev_awvalid, prev_wvalid;
    int   drop_err = 0, hold_err = 0, rr_err = 0;
    logic [31:0] q_data[$];
    logic [3:0]  q_idx[$];
    logic        q_last[$];
    logic        q_err[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_aw_hs <= 1'b0; prev_w_hs <= 1'b0; prev_awvalid <= 1'b0; prev_wvalid <= 1'b0;
        end else begin
            if (prev_aw_hs && axi_bus.awvalid) drop_err <= drop_err + 1;
            if (prev_w_hs && axi_bus.wvalid) drop_err <= drop_err + 1;
            if ((prev_awvalid && !prev_aw_hs && !axi_bus.awvalid) ||
                (prev_wvalid && !prev_w_hs && !axi_bus.wvalid)) hold_err <= hold_err + 1;
            if (axi_bus.rvalid && (axi_bus.rready !== resp_ready)) rr_err <= rr_err + 1;
            prev_aw_hs   <= axi_bus.awvalid && axi_bus.awready;
            prev_w_hs    <= axi_bus.wvalid && axi_bus.wready;
            prev_awvalid <= axi_bus.awvalid;
            prev_wvalid  <= axi_bus.wvalid;
            if (resp_valid && resp_ready) begin
                q_data.push_back(resp_data);
                q_idx.push_back(resp_index);
                q_last.push_back(resp_last);
                q_err.push_back(resp_error);
            end
        end
    end

    // resp_ready: held high, or cycled 1,0,0,1 while toggle_en is set
    logic       toggle_en = 1'b0;
    logic [3:0] ready_pat = 4'b1001;
    int         tcnt = 0;
    always @(negedge clk) begin
        if (toggle_en) begin
            resp_ready = ready_pat[tcnt % 4];
            tcnt++;
        end else begin
            resp_ready = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_q();
        q_data.delete(); q_idx.delete(); q_last.delete(); q_err.delete();
    endtask

    task automatic send_req(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] strb);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd; req_wstrb = strb;
        while (!req_ready && t < 50) begin @(negedge clk); t++; end
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL req_accept addr=%h got req_ready=%b expected 1", addr, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        vectors++;
        if ((wr ? (axi_bus.awvalid & axi_bus.wvalid) : axi_bus.arvalid) !== 1'b1) begin
            miscompares++;
            $display("FAIL addr_valid_latency wr=%b got aw=%b w=%b ar=%b expected 1",
                     wr, axi_bus.awvalid, axi_bus.wvalid, axi_bus.arvalid);
        end
    endtask

    task automatic wait_resps(input int n, input int budget);
        int t = 0;
        while (q_data.size() < n && t < budget) begin @(negedge clk); t++; end
        repeat (4) @(negedge clk);
        vectors++;
        if (q_data.size() != n) begin
            miscompares++;
            $display("FAIL resp_count got %0d expected %0d", q_data.size(), n);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req_ready, axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid,
             axi_bus.rready, axi_bus.bready, resp_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got rr=%b ar=%b aw=%b w=%b r=%b b=%b rv=%b expected all 0",
                     req_ready, axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid,
                     axi_bus.rready, axi_bus.bready, resp_valid);
        end
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready got %b expected 1", req_ready);
        end
    endtask

    task automatic test_refill_wrap();
        clear_q();
        send_req(1'b0, 32'h48, 32'h0, 4'h0);
        wait_resps(16, 200);
        vectors++;
        if ({ar_addr_s, ar_len_s, ar_burst_s, ar_size_s} !== {32'h48, 8'd15, 2'b10, 3'd2}) begin
            miscompares++;
            $display("FAIL refill_ar got addr=%h len=%0d burst=%0d size=%0d expected 48/15/2/2",
                     ar_addr_s, ar_len_s, ar_burst_s, ar_size_s);
        end
        // line at 0x40 covers words 16..31; first beat is word 18
        for (int k = 0; k < 16; k++) begin
            logic [3:0]  ei;
            logic [31:0] ed;
            ei = 4'((2 + k) % 16);
            ed = 32'h1010 + 32'(ei);
            vectors++;
            if ({q_data[k], q_idx[k], q_last[k], q_err[k]} !== {ed, ei, (k == 15), 1'b0}) begin
                miscompares++;
                $display("FAIL refill_beat%0d got data=%h idx=%0d last=%b err=%b expected %h/%0d/%b/0",
                         k, q_data[k], q_idx[k], q_last[k], q_err[k], ed, ei, (k == 15));
            end
        end
    endtask

    task automatic test_write();
        clear_q();
        send_req(1'b1, 32'h100, 32'hDEADBEEF, 4'b0011);
        wait_resps(1, 50);
        vectors++;
        if ({aw_addr_s, aw_len_s, aw_burst_s, w_last_s, w_data_s, w_strb_s} !==
            {32'h100, 8'd0, 2'b01, 1'b1, 32'hDEADBEEF, 4'b0011}) begin
            miscompares++;
            $display("FAIL write_aw_w got addr=%h len=%0d burst=%0d wlast=%b data=%h strb=%b expected 100/0/1/1/deadbeef/0011",
                     aw_addr_s, aw_len_s, aw_burst_s, w_last_s, w_data_s, w_strb_s);
        end
        vectors++;
        if ({q_idx[0], q_last[0], q_err[0]} !== {4'd0, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL write_resp got idx=%0d last=%b err=%b expected 0/1/0", q_idx[0], q_last[0], q_err[0]);
        end
        clear_q();
        send_req(1'b0, 32'h100, 32'h0, 4'h0);
        wait_resps(16, 200);
        // word 0x40 held 0x00001040; only its low half was overwritten
        vectors++;
        if ({q_data[0], q_idx[0]} !== {32'h0000BEEF, 4'd0}) begin
            miscompares++;
            $display("FAIL write_readback got data=%h idx=%0d expected 0000beef/0", q_data[0], q_idx[0]);
        end
        vectors++;
        if ({q_data[1], q_idx[1]} !== {32'h00001041, 4'd1}) begin
            miscompares++;
            $display("FAIL write_readback_next got data=%h idx=%0d expected 00001041/1", q_data[1], q_idx[1]);
        end
    endtask

    task automatic test_out_of_range();
        clear_q();
        send_req(1'b1, 32'h1000, 32'h12345678, 4'hF);
        wait_resps(1, 50);
        vectors++;
        if ({q_last[0], q_err[0]} !== 2'b11) begin
            miscompares++;
            $display("FAIL oor_write got last=%b err=%b expected 1/1", q_last[0], q_err[0]);
        end
        clear_q();
        send_req(1'b0, 32'h1000, 32'h0, 4'h0);
        wait_resps(16, 200);
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if ({q_idx[k], q_err[k], q_last[k]} !== {4'(k), 1'b1, (k == 15)}) begin
                miscompares++;
                $display("FAIL oor_refill_beat%0d got idx=%0d err=%b last=%b expected %0d/1/%b",
                         k, q_idx[k], q_err[k], q_last[k], k, (k == 15));
            end
        end
    endtask

    task automatic test_backpressure();
        int rr_before;
        rr_before = rr_err;
        clear_q();
        tcnt = 0;
        toggle_en = 1'b1;
        send_req(1'b0, 32'h0, 32'h0, 4'h0);
        wait_resps(16, 400);
        toggle_en = 1'b0;
        for (int k = 0; k < 16; k++) begin
            vectors++;
            if ({q_data[k], q_idx[k]} !== {32'h1000 + 32'(k), 4'(k)}) begin
                miscompares++;
                $display("FAIL bp_beat%0d got data=%h idx=%0d expected %h/%0d",
                         k, q_data[k], q_idx[k], 32'h1000 + 32'(k), k);
            end
        end
        vectors++;
        if (rr_err != rr_before) begin
            miscompares++;
            $display("FAIL bp_rready_follow got %0d mismatched cycles expected 0", rr_err - rr_before);
        end
    endtask

    task automatic test_aw_w_order();
        int lat_aw[3] = '{3, 0, 0};
        int lat_w[3]  = '{0, 3, 0};
        for (int i = 0; i < 3; i++) begin
            int b0, d0, h0;
            b0 = b_count; d0 = drop_err; h0 = hold_err;
            aw_lat = lat_aw[i]; w_lat = lat_w[i];
            clear_q();
            send_req(1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
            wait_resps(1, 50);
            vectors++;
            if ((b_count - b0) != 1) begin
                miscompares++;
                $display("FAIL order%0d_b_count got %0d expected 1", i, b_count - b0);
            end
            vectors++;
            if ((aw_hs_cyc - w_hs_cyc) != (lat_aw[i] - lat_w[i])) begin
                miscompares++;
                $display("FAIL order%0d_hs_gap got %0d expected %0d", i, aw_hs_cyc - w_hs_cyc, lat_aw[i] - lat_w[i]);
            end
            vectors++;
            if ({drop_err - d0, hold_err - h0} !== {32'd0, 32'd0}) begin
                miscompares++;
                $display("FAIL order%0d_valid_timing got drops=%0d holds=%0d expected 0/0", i, drop_err - d0, hold_err - h0);
            end
            vectors++;
            if (mem[(32'h200 >> 2) + i] !== 32'hA0 + 32'(i)) begin
                miscompares++;
                $display("FAIL order%0d_mem got %h expected %h", i, mem[(32'h200 >> 2) + i], 32'hA0 + 32'(i));
            end
        end
        aw_lat = 0; w_lat = 0;
    endtask

    task automatic test_async_reset();
        int t = 0;
        clear_q();
        send_req(1'b0, 32'h0, 32'h0, 4'h0);
        while (q_data.size() < 5 && t < 100) begin @(negedge clk); t++; end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({req_ready, axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid,
             axi_bus.rready, axi_bus.bready, resp_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL async_reset_outputs got rr=%b ar=%b aw=%b w=%b r=%b b=%b rv=%b expected all 0",
                     req_ready, axi_bus.arvalid, axi_bus.awvalid, axi_bus.wvalid,
                     axi_bus.rready, axi_bus.bready, resp_valid);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++;
        if (req_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_ready got %b expected 1", req_ready);
        end
        clear_q();
        send_req(1'b1, 32'h300, 32'h5A5A5A5A, 4'hF);
        wait_resps(1, 50);
        vectors++;
        if ({q_last[0], q_err[0], mem[32'h300 >> 2]} !== {1'b1, 1'b0, 32'h5A5A5A5A}) begin
            miscompares++;
            $display("FAIL async_reset_write got last=%b err=%b mem=%h expected 1/0/5a5a5a5a",
                     q_last[0], q_err[0], mem[32'h300 >> 2]);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000 + 32'(i);
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
        rst_n = 1'b0;
        test_reset();
        test_refill_wrap();
        test_write();
        test_out_of_range();
        test_backpressure();
        test_aw_w_order();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
